// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// Fetch front end between the program counter and decode. Issues one
// instruction-memory request at a time. Each returned word is buffered in a
// small FIFO together with its PC+4, and a redirect flushes both the FIFO and
// any in-flight request.
//
// Handshakes:
//   imem_req_o/imem_ack_i : a request is raised from a register and held, with
//                           imem_addr_o stable, until the cycle imem_ack_i=1.
//                           Once raised it is never withdrawn, even on redirect.
//   dec_valid_o/dec_ready_i : the head entry transfers on any cycle where both
//                           are high. dec_valid_o is forced low during redirect.
module instr_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [31:0]                pc_next_i,
    input  logic                       redirect_i,
    output logic                       pc_en_o,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_rdata_i,
    output logic                       dec_valid_o,
    output logic [31:0]                dec_instr_o,
    output logic [31:0]                dec_pc_plus_4_o,
    input  logic                       dec_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [1:0]                 state_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            imem_req_q, imem_req_d;
    logic [31:0]     imem_addr_q, imem_addr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc4_mem   [DEPTH];

    logic            fire;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic [31:0]     push_pc4;

    // Handshake qualifiers shared by the FSM and the FIFO.
    always_comb begin
        fifo_empty = (count_q == '0);
        // Only fetch when no request is outstanding and a slot is guaranteed.
        fire       = (state_q == ST_IDLE) && (count_q < DEPTH_C) && !redirect_i;
        // A returned word is kept only when it belongs to the current path.
        push       = (state_q == ST_REQ) && imem_ack_i && !redirect_i;
        pop        = !fifo_empty && !redirect_i && dec_ready_i;
        // Modulo 2^32 wrap of PC+4 falls out of the 32-bit add.
        push_pc4   = imem_addr_q + 32'd4;
    end

    // Fetch FSM next-state and request register next values.
    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    imem_addr_d = pc_next_i;
                    imem_req_d  = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack_i) begin
                    // Data is pushed (or discarded on redirect) by the FIFO logic.
                    imem_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (redirect_i) begin
                    // Request cannot be withdrawn; wait out the stale ack.
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_ack_i) begin
                    imem_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                imem_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // FIFO occupancy and pointer next values; redirect flushes everything.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'd0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            instr_mem[wr_ptr_q] <= imem_rdata_i;
            pc4_mem[wr_ptr_q]   <= push_pc4;
        end
    end

    // Output drive; head data reads as zero when the FIFO is empty.
    always_comb begin
        pc_en_o         = fire;
        imem_req_o      = imem_req_q;
        imem_addr_o     = imem_addr_q;
        dec_valid_o     = !fifo_empty && !redirect_i;
        dec_instr_o     = fifo_empty ? 32'd0 : instr_mem[rd_ptr_q];
        dec_pc_plus_4_o = fifo_empty ? 32'd0 : pc4_mem[rd_ptr_q];
        count_o         = count_q;
        state_o         = state_q;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Consumer end of the program-counter interface. It takes the fetch address `pc_next` and issues one instruction-memory request at a time with a req/ack handshake. Returned words are buffered in a small FIFO together with their PC+4, and handed to decode over a valid/ready handshake. It also tells the PC when to advance, and flushes all fetched and in-flight work on a branch/jump redirect.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_next`  in  32  current fetch address from the program counter.
- `redirect`  in  1  branch/jump/jr taken this cycle; flush request.
- `pc_en`  out  1  PC may advance to its next value this cycle.
- `imem_req`  out  1  instruction-memory request, registered.
- `imem_addr`  out  32  request address, registered.
- `imem_ack`  in  1  memory returns data this cycle.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `dec_valid`  out  1  head entry available to decode.
- `dec_instr`  out  32  head instruction.
- `dec_pc_plus_4`  out  32  address of head instruction + 4.
- `dec_ready`  in  1  decode accepts head this cycle.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **State machine** has three states: IDLE, REQ and DROP.
- **Fire condition:** `fire = (state==IDLE) && (count<DEPTH) && !redirect`. `pc_en = fire` (combinational).
- The PC loads its redirect target whenever `redirect`=1, regardless of `pc_en`.
- **IDLE**
  - On `fire`: `imem_addr <= pc_next`, `imem_req <= 1`, next state REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `imem_req` and `imem_addr` stay stable until `imem_ack`.
  - On `imem_ack` && !`redirect`: push {`imem_rdata`, `imem_addr`+4} into the FIFO, `imem_req <= 0`, next state IDLE.
  - On `imem_ack` && `redirect`: discard the data, `imem_req <= 0`, next state IDLE.
  - On `redirect` && !`imem_ack`: next state DROP, with `imem_req` still held.
- **DROP**
  - `imem_req` stays high; the protocol forbids withdrawing a request.
  - On `imem_ack`: discard the data, `imem_req <= 0`, next state IDLE.
  - A further `redirect` while in DROP is harmless; stay in DROP.
- **FIFO push/pop**
  - A push happens only from REQ, which was entered with `count<DEPTH` and is the single outstanding request, so a push can never overflow.
  - A pop occurs when `dec_valid && dec_ready`.
- **FIFO outputs**
  - `dec_valid = (count!=0) && !redirect`.
  - `dec_instr` and `dec_pc_plus_4` come from the head entry. Both are 0 when `count==0`.
- **Simultaneous push and pop** in one cycle: `count` is unchanged and the pointers advance independently.
- **Redirect**
  - FIFO flushes: `count`, read pointer and write pointer return to 0 at the next edge.
  - No pop is taken in the redirect cycle.
  - A concurrent push is suppressed.
- **Arithmetic rules**
  - PC+4 is modulo 2^32; 0xFFFFFFFC+4 = 0x00000000.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.

## Timing
- **Reset values**
  - state IDLE
  - `imem_req`=0, `imem_addr`=0
  - `count`=0, both pointers 0
  - `dec_valid`=0, `dec_instr`=0, `dec_pc_plus_4`=0
  - `pc_en`=1 unless `redirect` is high
- **Reset mid-operation:** reset overrides everything, including an outstanding REQ or DROP. An `imem_ack` arriving the cycle after reset is ignored, because the state is IDLE.
- **Fetch sequence**
  - Cycle T: `fire` (PC advances at the edge ending T).
  - T+1: `imem_req`=1, `imem_addr`=`pc_next`(T).
  - Ack at cycle T+k (k≥1): push at the edge ending T+k.
  - T+k+1: `dec_valid`=1 and `count` increments. The next `fire` is possible in this cycle.
- **Throughput:** one instruction per k+1 cycles, i.e. one per 2 cycles with a 1-cycle ack.
- **Redirect timing**
  - Redirect in cycle R: `dec_valid`=0 in R, `count`=0 in R+1.
  - If the state in R+1 is IDLE, `fire` fetches the target at R+1.
- **Full FIFO:** with `count`=DEPTH and `dec_ready`=0, `pc_en` stays 0 and no request issues. The first pop reopens `fire` in the following cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `imem_ack` toggling → all outputs at their reset values, no push.
- **Single fetch:** `pc_next`=0x00000000, ack 1 cycle after `imem_req` with rdata 0x20080005 → `dec_valid` high 3 cycles after `fire`, `dec_instr`=0x20080005, `dec_pc_plus_4`=0x00000004.
- **Fill:** DEPTH=4, `dec_ready`=0, PC stepping by 4 from 0x100 → `count` reaches 4, `pc_en`=0 and `imem_req`=0 persist. Then raise `dec_ready` → entries drain in order with PC+4 = 0x104, 0x108, 0x10C, 0x110.
- **Redirect while outstanding:** redirect while in REQ, ack 3 cycles later with 0xDEADBEEF → state DROP, word never appears, `count`=0. The next fetch uses the target address.
- **Redirect with ack in the same cycle**, with 2 entries queued → no push, no pop, `count`=0 next cycle, state IDLE.
- **Reset during REQ:** `rst`=1 while `imem_req`=1, ack arriving in the cycle after reset → nothing pushed, `imem_req`=0.
